object_scanner: RTL and testbench

Post-frame readout stage downstream of the detection top level. On a frame-done pulse it walks every label from 1 to `num_labels` and drives `obj_id` into the connected-components statistics port. It waits out the read latency, then captures `obj_area`/`obj_x`/`obj_y` and drops objects smaller than a minimum area. Surviving objects leave as records on a valid/ready stream toward the host/overlay logic.

---
 rtl/object_scanner_pkg.sv | 22 ++
 rtl/object_scanner.sv | 173 +++++++++++++++++
 tb/tb_object_scanner.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/object_scanner_pkg.sv
// Shared types and defaults for the post-frame object scanner.
// Holds the scanner FSM encoding and default widths.
package object_scanner_pkg;

  localparam int OS_LBL_WIDTH = 8;
  localparam int OS_LOC_SIZE  = 16;

  typedef enum logic [2:0] {
    OS_IDLE    = 3'd0,
    OS_ISSUE   = 3'd1,
    OS_WAIT    = 3'd2,
    OS_CAPTURE = 3'd3,
    OS_EMIT    = 3'd4,
    OS_DONE    = 3'd5
  } os_state_e;

  // Wait-counter preload for a given statistics read latency.
  function automatic logic [3:0] os_wait_load(input int rl);
    return 4'(rl - 1);
  endfunction

endpackage

// File: rtl/object_scanner.sv
// Post-frame readout: walks labels 1..num_labels through the
// connected-components statistics port, drops objects below MIN_AREA
// and streams survivors out on a valid/ready record interface.
//
// Ports:
//   clk, reset        clock, async active-high reset
//   frame_done        one-cycle pulse that starts a scan
//   num_labels        label count for the frame (0 = background only)
//   obj_id            label presented to the statistics port
//   obj_area/x/y      statistics, valid READ_LATENCY cycles after obj_id
//   rec_valid/ready   record handshake
//   rec_label/area/x/y record payload
//   busy              scan in progress
//   scan_done         one-cycle pulse when a scan completes
//   obj_count         records emitted by the last completed scan
//   missed_frame      sticky, frame_done seen while busy
module object_scanner
  import object_scanner_pkg::*;
#(
  parameter int LBL_WIDTH    = OS_LBL_WIDTH,
  parameter int LOC_SIZE     = OS_LOC_SIZE,
  parameter int READ_LATENCY = 2,
  parameter int MIN_AREA     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_done,
  input  logic [LBL_WIDTH-1:0] num_labels,
  output logic [LBL_WIDTH-1:0] obj_id,
  input  logic [LOC_SIZE-1:0]  obj_area,
  input  logic [LOC_SIZE-1:0]  obj_x,
  input  logic [LOC_SIZE-1:0]  obj_y,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [LBL_WIDTH-1:0] rec_label,
  output logic [LOC_SIZE-1:0]  rec_area,
  output logic [LOC_SIZE-1:0]  rec_x,
  output logic [LOC_SIZE-1:0]  rec_y,
  output logic                 busy,
  output logic                 scan_done,
  output logic [LBL_WIDTH-1:0] obj_count,
  output logic                 missed_frame
);

  localparam logic [3:0] WAIT_LOAD = os_wait_load(READ_LATENCY);
  localparam logic [LOC_SIZE-1:0] MIN_A = LOC_SIZE'(MIN_AREA);

  os_state_e            state_q;
  logic [LBL_WIDTH-1:0] n_lat_q;
  logic [LBL_WIDTH-1:0] label_q;
  logic [LBL_WIDTH-1:0] cnt_q;
  logic [3:0]           wait_q;
  logic [LBL_WIDTH-1:0] obj_id_q;
  logic                 rec_valid_q;
  logic [LBL_WIDTH-1:0] rec_label_q;
  logic [LOC_SIZE-1:0]  rec_area_q;
  logic [LOC_SIZE-1:0]  rec_x_q;
  logic [LOC_SIZE-1:0]  rec_y_q;
  logic                 busy_q;
  logic                 scan_done_q;
  logic [LBL_WIDTH-1:0] obj_count_q;
  logic                 missed_q;

  // Advance step: compare before incrementing so an all-ones
  // label count terminates instead of wrapping to 0.
  logic                 last_lbl;
  os_state_e            adv_state_d;
  logic [LBL_WIDTH-1:0] label_d;
  logic [LBL_WIDTH-1:0] cnt_d;
  logic                 keep;

  always_comb begin
    last_lbl    = (label_q == n_lat_q);
    adv_state_d = last_lbl ? OS_DONE : OS_ISSUE;
    label_d     = last_lbl ? label_q : label_q + 1'b1;
    cnt_d       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    keep        = (obj_area >= MIN_A);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= OS_IDLE;
      n_lat_q     <= '0;
      label_q     <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      obj_id_q    <= '0;
      rec_valid_q <= 1'b0;
      rec_label_q <= '0;
      rec_area_q  <= '0;
      rec_x_q     <= '0;
      rec_y_q     <= '0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
      obj_count_q <= '0;
      missed_q    <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      if (frame_done && busy_q) begin
        missed_q <= 1'b1;
      end
      unique case (state_q)
        OS_IDLE: begin
          if (frame_done) begin
            n_lat_q <= num_labels;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            if (num_labels == '0) begin
              state_q <= OS_DONE;
            end else begin
              label_q <= LBL_WIDTH'(1);
              state_q <= OS_ISSUE;
            end
          end
        end
        OS_ISSUE: begin
          obj_id_q <= label_q;
          wait_q   <= WAIT_LOAD;
          state_q  <= OS_WAIT;
        end
        OS_WAIT: begin
          if (wait_q == 4'd0) begin
            state_q <= OS_CAPTURE;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        OS_CAPTURE: begin
          if (keep) begin
            rec_label_q <= obj_id_q;
            rec_area_q  <= obj_area;
            rec_x_q     <= obj_x;
            rec_y_q     <= obj_y;
            rec_valid_q <= 1'b1;
            state_q     <= OS_EMIT;
          end else begin
            label_q <= label_d;
            state_q <= adv_state_d;
          end
        end
        OS_EMIT: begin
          if (rec_ready) begin
            rec_valid_q <= 1'b0;
            cnt_q       <= cnt_d;
            label_q     <= label_d;
            state_q     <= adv_state_d;
          end
        end
        OS_DONE: begin
          obj_count_q <= cnt_q;
          scan_done_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= OS_IDLE;
        end
        default: begin
          state_q <= OS_IDLE;
        end
      endcase
    end
  end

  assign obj_id       = obj_id_q;
  assign rec_valid    = rec_valid_q;
  assign rec_label    = rec_label_q;
  assign rec_area     = rec_area_q;
  assign rec_x        = rec_x_q;
  assign rec_y        = rec_y_q;
  assign busy         = busy_q;
  assign scan_done    = scan_done_q;
  assign obj_count    = obj_count_q;
  assign missed_frame = missed_q;

endmodule

// File: tb/tb_object_scanner.sv
// Directed bench for object_scanner with a 2-cycle statistics model.
// Records, obj_id visits and scan_done pulses are logged at negedge.
module tb_object_scanner;

  typedef struct {
    logic [7:0]  l;
    logic [15:0] a;
    logic [15:0] x;
    logic [15:0] y;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_done = 1'b0;
  logic [7:0]  num_labels = '0;
  logic [7:0]  obj_id;
  logic [15:0] obj_area, obj_x, obj_y;
  logic        rec_valid;
  logic        rec_ready = 1'b1;
  logic [7:0]  rec_label;
  logic [15:0] rec_area, rec_x, rec_y;
  logic        busy, scan_done, missed_frame;
  logic [7:0]  obj_count;

  logic [15:0] area_tbl [256];
  logic [15:0] x_tbl    [256];
  logic [15:0] y_tbl    [256];
  logic [7:0]  id_p1 = '0;
  logic [7:0]  id_p2 = '0;

  rec_t        recs[$];
  logic [7:0]  ids[$];
  logic [7:0]  last_id = '0;
  int          pulses = 0;
  int          vcnt = 0;
  int          viol = 0;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  rec_t        prev_p;

  int n_chk = 0;
  int n_pass = 0;

  object_scanner #(
    .LBL_WIDTH(8), .LOC_SIZE(16),
    .READ_LATENCY(2), .MIN_AREA(4)
  ) dut (
    .clk(clk), .reset(reset),
    .frame_done(frame_done), .num_labels(num_labels),
    .obj_id(obj_id),
    .obj_area(obj_area), .obj_x(obj_x), .obj_y(obj_y),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_label(rec_label), .rec_area(rec_area),
    .rec_x(rec_x), .rec_y(rec_y),
    .busy(busy), .scan_done(scan_done),
    .obj_count(obj_count), .missed_frame(missed_frame)
  );

  always #5 clk = ~clk;

  // Statistics memory: data follows obj_id two clocks later.
  always @(posedge clk) begin
    id_p1 <= obj_id;
    id_p2 <= id_p1;
  end
  assign obj_area = area_tbl[id_p2];
  assign obj_x    = x_tbl[id_p2];
  assign obj_y    = y_tbl[id_p2];

  always @(negedge clk) begin
    if (reset) begin
      prev_v <= 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        if (!rec_valid || rec_label != prev_p.l ||
            rec_area != prev_p.a || rec_x != prev_p.x ||
            rec_y != prev_p.y)
          viol <= viol + 1;
      end
      prev_v <= rec_valid;
      prev_r <= rec_ready;
      prev_p <= '{rec_label, rec_area, rec_x, rec_y};
      if (rec_valid) vcnt <= vcnt + 1;
      if (rec_valid && rec_ready)
        recs.push_back('{rec_label, rec_area, rec_x, rec_y});
      if (scan_done) pulses <= pulses + 1;
    end
    if (obj_id != last_id && obj_id != 8'd0) ids.push_back(obj_id);
    last_id <= obj_id;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fd();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (scan_done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(scan_done), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (rec_valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(rec_valid), 32'd1);
  endtask

  task automatic clear_logs();
    recs.delete();
    ids.delete();
    pulses = 0;
    vcnt = 0;
  endtask

  task automatic set_areas(input logic [15:0] a1, input logic [15:0] a2,
                           input logic [15:0] a3);
    for (int i = 0; i < 256; i++) area_tbl[i] = '0;
    area_tbl[1] = a1;
    area_tbl[2] = a2;
    area_tbl[3] = a3;
  endtask

  initial begin
    int oerr;
    for (int i = 0; i < 256; i++) begin
      area_tbl[i] = '0;
      x_tbl[i] = 16'(i * 3 + 100);
      y_tbl[i] = 16'(i * 5 + 200);
    end
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_obj_id", 32'(obj_id), 0);
    chk("rst_rec_valid", 32'(rec_valid), 0);
    chk("rst_rec_label", 32'(rec_label), 0);
    chk("rst_rec_area", 32'(rec_area), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_scan_done", 32'(scan_done), 0);
    chk("rst_obj_count", 32'(obj_count), 0);
    chk("rst_missed", 32'(missed_frame), 0);

    // Areas {10,2,7}: labels 1 and 3 survive.
    clear_logs();
    set_areas(16'd10, 16'd2, 16'd7);
    num_labels = 8'd3;
    rec_ready = 1'b1;
    pulse_fd();
    chk("t1_busy_t1", 32'(busy), 1);
    tick();
    chk("t1_obj_id_t2", 32'(obj_id), 1);
    wait_done("t1_done", 200);
    chk("t1_obj_count", 32'(obj_count), 2);
    chk("t1_busy_end", 32'(busy), 0);
    tick();
    chk("t1_pulses", 32'(pulses), 1);
    chk("t1_nrec", 32'(recs.size()), 2);
    if (recs.size() == 2) begin
      chk("t1_r0_label", 32'(recs[0].l), 1);
      chk("t1_r0_area", 32'(recs[0].a), 10);
      chk("t1_r0_x", 32'(recs[0].x), 103);
      chk("t1_r0_y", 32'(recs[0].y), 205);
      chk("t1_r1_label", 32'(recs[1].l), 3);
      chk("t1_r1_area", 32'(recs[1].a), 7);
      chk("t1_r1_x", 32'(recs[1].x), 109);
      chk("t1_r1_y", 32'(recs[1].y), 215);
    end
    chk("t1_nids", 32'(ids.size()), 3);
    if (ids.size() == 3) begin
      chk("t1_id0", 32'(ids[0]), 1);
      chk("t1_id1", 32'(ids[1]), 2);
      chk("t1_id2", 32'(ids[2]), 3);
    end

    // Zero labels: straight to DONE.
    clear_logs();
    num_labels = 8'd0;
    pulse_fd();
    chk("t2_busy", 32'(busy), 1);
    chk("t2_done_early", 32'(scan_done), 0);
    tick();
    chk("t2_done", 32'(scan_done), 1);
    chk("t2_obj_count", 32'(obj_count), 0);
    tick();
    chk("t2_busy_end", 32'(busy), 0);
    chk("t2_nrec", 32'(recs.size()), 0);
    chk("t2_pulses", 32'(pulses), 1);

    // Back-pressure on the first record for 5 cycles.
    clear_logs();
    set_areas(16'd5, 16'd6, 16'd0);
    num_labels = 8'd2;
    rec_ready = 1'b0;
    pulse_fd();
    wait_valid("t3_valid_seen", 50);
    chk("t3_label", 32'(rec_label), 1);
    chk("t3_area", 32'(rec_area), 5);
    repeat (5) tick();
    chk("t3_hold_id", 32'(obj_id), 1);
    chk("t3_hold_valid", 32'(rec_valid), 1);
    rec_ready = 1'b1;
    tick();
    chk("t3_valid_drop", 32'(rec_valid), 0);
    chk("t3_vcnt", 32'(vcnt), 6);
    wait_done("t3_done", 200);
    chk("t3_obj_count", 32'(obj_count), 2);
    tick();
    chk("t3_nrec", 32'(recs.size()), 2);
    if (recs.size() == 2) chk("t3_r1_area", 32'(recs[1].a), 6);

    // Second frame_done mid-scan; areas at the filter boundary.
    clear_logs();
    set_areas(16'd4, 16'd3, 16'd8);
    num_labels = 8'd3;
    pulse_fd();
    repeat (3) tick();
    chk("t4_missed_pre", 32'(missed_frame), 0);
    pulse_fd();
    chk("t4_missed", 32'(missed_frame), 1);
    wait_done("t4_done", 200);
    chk("t4_obj_count", 32'(obj_count), 2);
    repeat (20) tick();
    chk("t4_pulses", 32'(pulses), 1);
    chk("t4_busy_end", 32'(busy), 0);
    chk("t4_nrec", 32'(recs.size()), 2);
    if (recs.size() == 2) begin
      chk("t4_r0_label", 32'(recs[0].l), 1);
      chk("t4_r1_label", 32'(recs[1].l), 3);
    end
    chk("t4_missed_sticky", 32'(missed_frame), 1);

    // Reset during EMIT, then a clean scan.
    clear_logs();
    set_areas(16'd9, 16'd9, 16'd0);
    num_labels = 8'd2;
    rec_ready = 1'b0;
    pulse_fd();
    wait_valid("t5_valid_seen", 50);
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(rec_valid), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_obj_id", 32'(obj_id), 0);
    chk("t5_rst_label", 32'(rec_label), 0);
    chk("t5_rst_missed", 32'(missed_frame), 0);
    tick();
    reset = 1'b0;
    rec_ready = 1'b1;
    tick();
    clear_logs();
    pulse_fd();
    wait_done("t5_done", 200);
    chk("t5_obj_count", 32'(obj_count), 2);
    tick();
    chk("t5_nrec", 32'(recs.size()), 2);
    if (recs.size() == 2) chk("t5_r0_label", 32'(recs[0].l), 1);
    if (ids.size() > 0) chk("t5_first_id", 32'(ids[0]), 1);
    else chk("t5_nids", 32'(ids.size()), 2);

    // Full label range, every object exactly at MIN_AREA.
    clear_logs();
    for (int i = 0; i < 256; i++) area_tbl[i] = 16'd4;
    num_labels = 8'd255;
    pulse_fd();
    wait_done("t6_done", 2000);
    chk("t6_obj_count", 32'(obj_count), 255);
    repeat (20) tick();
    chk("t6_nrec", 32'(recs.size()), 255);
    if (recs.size() > 0) chk("t6_last", 32'(recs[$].l), 255);
    oerr = 0;
    foreach (recs[i]) if (recs[i].l != 8'(i + 1)) oerr++;
    chk("t6_order", 32'(oerr), 0);
    chk("t6_pulses", 32'(pulses), 1);
    chk("t6_busy_end", 32'(busy), 0);

    chk("stable_payload", 32'(viol), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
